// File: rtl/dr_pkg.sv
// Shared encodings for the clocked-to-dual-rail byte feeder.
package dr_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DRIVE     = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ST_RTZ       = 3'd3;
  localparam logic [2:0] ST_WAIT_NULL = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    DRIVE     = ST_DRIVE,
    WAIT_ACK  = ST_WAIT_ACK,
    RTZ       = ST_RTZ,
    WAIT_NULL = ST_WAIT_NULL,
    DONE      = ST_DONE
  } state_t;

  // Dual-rail codes, ordered {bit1, bit0}
  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_ZERO = 2'b01;
  localparam logic [1:0] DR_ONE  = 2'b10;

  // Map a data bit onto its dual-rail code
  function automatic logic [1:0] dr_encode(input logic b);
    return b ? DR_ONE : DR_ZERO;
  endfunction

endpackage

// File: rtl/dr_sync.sv
// Multi-flop synchroniser for one asynchronous rail.
module dr_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the async level through the flop chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/dr_byte_feeder.sv
// Serialises a parallel word LSB-first onto a four-phase dual-rail link.
import dr_pkg::*;

module dr_byte_feeder #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit0,
  output logic             bit1,
  input  logic             parity0,
  input  logic             parity1,
  output logic             res_valid,
  output logic             res_even,
  output logic             proto_err
);

  localparam int unsigned    IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t                 state;
  logic [WIDTH-1:0]       sh;
  logic [IDX_W-1:0]       idx;
  logic                   last_even;
  logic [SYNC_STAGES-1:0] warm;
  logic                   p0s;
  logic                   p1s;
  logic                   rails_null_c;
  logic                   sync_ok_c;

  dr_sync #(.STAGES(SYNC_STAGES)) u_sync_p0 (
    .clk   (clk),
    .reset (reset),
    .d     (parity0),
    .q     (p0s)
  );

  dr_sync #(.STAGES(SYNC_STAGES)) u_sync_p1 (
    .clk   (clk),
    .reset (reset),
    .d     (parity1),
    .q     (p1s)
  );

  assign rails_null_c = !p0s && !p1s;
  assign sync_ok_c    = warm[SYNC_STAGES-1];

  // Synchroniser outputs only mean something once the chain has refilled after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) warm <= '0;
    else       warm <= {warm[SYNC_STAGES-2:0], 1'b1};
  end

  // Handshake FSM with registered rails and result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sh          <= '0;
      idx         <= '0;
      last_even   <= 1'b0;
      {bit1, bit0} <= DR_NULL;
      in_ready    <= 1'b0;
      res_valid   <= 1'b0;
      res_even    <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      in_ready  <= 1'b0;
      if (p0s && p1s) proto_err <= 1'b1;

      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sh    <= in_data;
            idx   <= '0;
            state <= DRIVE;
          end else begin
            in_ready <= sync_ok_c && rails_null_c;
          end
        end
        DRIVE: begin
          {bit1, bit0} <= dr_encode(sh[0]);
          state        <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // Return-to-zero is issued on the same edge that sees the ack
          if (!rails_null_c) begin
            last_even    <= p1s;
            {bit1, bit0} <= DR_NULL;
            state        <= WAIT_NULL;
          end
        end
        RTZ: begin
          state <= WAIT_NULL;
        end
        WAIT_NULL: begin
          if (rails_null_c) begin
            if (idx == LAST_IDX) begin
              res_valid <= 1'b1;
              res_even  <= last_even;
              state     <= DONE;
            end else begin
              sh    <= sh >> 1;
              idx   <= idx + IDX_W'(1);
              state <= DRIVE;
            end
          end
        end
        DONE: begin
          in_ready <= sync_ok_c && rails_null_c;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
